// File: rtl/delay_line_pkg.sv
// Shared definitions for the RAM-backed programmable delay line controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package delay_line_pkg;

  // Controller phases: IDLE (no config or bad config), FILL (priming), RUN (primed)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Default geometry; derived widths follow the same clog2 rules used in the top
  localparam int DEF_DATA_WIDTH = 25;
  localparam int DEF_MAX_LEN    = 512;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_MAX_LEN);
  localparam int DEF_LEN_WIDTH  = $clog2(DEF_MAX_LEN + 1);

  // A delay is usable only if it is at least one sample and fits the RAM
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/ring_addr_ctr.sv
// Modulo-N wrapping address counter with enable, synchronous clear and run-time modulus.
// Latency: count updates on the clock edge after i_en/i_clr; o_cnt is the registered value.
// Backpressure: none; the counter advances only when the parent asserts i_en.
module ring_addr_ctr #(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [LEN_WIDTH-1:0]  i_mod,
  output logic [ADDR_WIDTH-1:0] o_cnt
);

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_last;

  // The modulus is never 0 while enabled, so mod-1 does not underflow in use
  assign w_last = (LEN_WIDTH'(r_cnt) == (i_mod - LEN_WIDTH'(1)));

  // Clear wins over advance; wrap back to 0 after the last slot of the ring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + ADDR_WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequences an external simple-dual-port RAM as a programmable 1..MAX_LEN sample delay line.
// Latency: out_data/out_valid one clock after the accept, delayed by len_q accepted samples.
// Backpressure: in_ready low in IDLE and during cfg_load; no backpressure on the output side.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_LEN    = DEF_MAX_LEN,
  localparam int ADDR_WIDTH = $clog2(MAX_LEN),
  localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_load,
  output logic                  cfg_err,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  primed,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len_q;
  logic [LEN_WIDTH-1:0]  r_fill_cnt;
  logic                  r_out_valid;
  logic                  r_cfg_err;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic                  w_len_ok;
  logic                  w_active;
  logic                  w_full;
  logic                  w_restart;
  logic                  w_accept;

  assign w_len_ok  = len_legal(32'(cfg_len), 32'(MAX_LEN));
  assign w_active  = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_full    = (r_fill_cnt == r_len_q);
  assign w_restart = cfg_load & w_len_ok;

  // A same-cycle cfg_load blocks the sample so nothing lands in the RAM mid-restart
  assign in_ready  = w_active & ~cfg_load;
  assign w_accept  = in_valid & in_ready;

  // Write and read share one pointer: the slot being overwritten holds the
  // sample from exactly len_q accepts ago, and the RAM is read-first.
  ring_addr_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_restart),
    .i_en  (w_accept),
    .i_mod (r_len_q),
    .o_cnt (w_ptr)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: any cfg_load restarts or parks; FILL becomes RUN on the priming accept
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      w_state_nxt = w_len_ok ? ST_FILL : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_FILL: begin
          if (w_accept && ((r_fill_cnt + LEN_WIDTH'(1)) == r_len_q)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Length latch and priming count; fill count saturates once the line is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q    <= '0;
      r_fill_cnt <= '0;
    end else if (w_restart) begin
      r_len_q    <= cfg_len;
      r_fill_cnt <= '0;
    end else if (w_accept && !w_full) begin
      r_fill_cnt <= r_fill_cnt + LEN_WIDTH'(1);
    end
  end

  // Output valid tracks the RAM read latency; cfg_err is a one-cycle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_out_valid <= w_accept & w_full;
      r_cfg_err   <= cfg_load & ~w_len_ok;
    end
  end

  assign ram_we    = w_accept;
  assign ram_re    = w_accept;
  assign ram_waddr = w_ptr;
  assign ram_raddr = w_ptr;
  assign ram_wdata = in_data;
  assign out_data  = ram_rdata;
  assign out_valid = r_out_valid;
  assign cfg_err   = r_cfg_err;
  assign primed    = (r_state == ST_RUN);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl with a behavioural RAM and a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_delay_line_ctrl;
  import delay_line_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int ML = DEF_MAX_LEN;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int LW = DEF_LEN_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_load = 1'b0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          primed;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_load(cfg_load), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .primed(primed),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // Simple-dual-port RAM, 1-cycle read latency, read-first on collision
  logic [DW-1:0] mem [ML];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Reference: the last len accepted samples since the most recent good load
  bit            m_active = 1'b0;
  int            m_len = 0;
  int            m_acc = 0;
  logic [DW-1:0] m_hist[$];
  bit            m_ov_exp = 1'b0;
  bit            m_err_exp = 1'b0;
  logic [DW-1:0] m_od_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_len = 0; m_acc = 0; m_hist.delete();
    m_ov_exp = 1'b0; m_err_exp = 1'b0;
  endtask

  // One clock: drive after negedge, check combinational outputs, step model, check registered outputs
  task automatic cycle(input bit ld, input logic [LW-1:0] len, input bit v, input logic [DW-1:0] d);
    bit acc;
    cfg_load = ld; cfg_len = len; in_valid = v; in_data = d;
    #1;
    acc = m_active && !ld && v;
    chk("in_ready", in_ready, m_active && !ld);
    chk("ram_we", ram_we, acc);
    chk("ram_re", ram_re, acc);
    if (acc) begin
      chk("ram_waddr", ram_waddr, m_acc % m_len);
      chk("ram_raddr", ram_raddr, m_acc % m_len);
      chk("ram_wdata", ram_wdata, d);
    end
    @(posedge clk);
    m_ov_exp = 1'b0; m_err_exp = 1'b0;
    if (ld) begin
      if (len >= 1 && int'(len) <= ML) begin
        m_active = 1'b1; m_len = int'(len); m_acc = 0; m_hist.delete();
      end else begin
        m_active = 1'b0; m_err_exp = 1'b1;
      end
    end else if (acc) begin
      if (m_hist.size() == m_len) begin
        m_ov_exp = 1'b1; m_od_exp = m_hist[0];
      end
      m_hist.push_back(d);
      if (m_hist.size() > m_len) void'(m_hist.pop_front());
      m_acc++;
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_ov_exp);
    chk("cfg_err", cfg_err, m_err_exp);
    chk("primed", primed, m_active && (m_hist.size() == m_len));
    if (m_ov_exp) chk("out_data", out_data, m_od_exp);
  endtask

  typedef struct {
    bit            ld;
    logic [LW-1:0] len;
    bit            v;
    logic [DW-1:0] d;
    bit            ov;
    logic [DW-1:0] od;
    bit            pr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // len=4, stream 0..9: primed after sample 3, outputs 0..5 from sample 4 on
    tbl[0] = '{1'b1, LW'(4), 1'b0, '0, 1'b0, '0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tbl[i+1] = '{1'b0, '0, 1'b1, DW'(i), (i >= 4), DW'(i - 4), (i >= 3)};
    end
    tbl[11] = '{1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1};

    // Reset state, held without and across clock edges
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_primed", primed, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_re", ram_re, 1'b0);
    chk("rst_waddr", ram_waddr, '0);
    chk("rst_raddr", ram_raddr, '0);
    rst_n = 1'b1;

    // Table-driven len=4 stream
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].ld, tbl[i].len, tbl[i].v, tbl[i].d);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_primed", primed, tbl[i].pr);
      if (tbl[i].ov) chk("tbl_out_data", out_data, tbl[i].od);
    end

    // len=3 with gaps: pointer holds, ordering preserved
    begin
      bit pat[9] = '{1, 0, 1, 1, 0, 0, 1, 1, 1};
      int dv = 10;
      cycle(1'b1, LW'(3), 1'b0, '0);
      for (int i = 0; i < 9; i++) begin
        cycle(1'b0, '0, pat[i], DW'(dv));
        if (pat[i]) dv++;
      end
      chk("gap_last_out", out_data, DW'(12));
    end

    // len=MAX_LEN: 1024 accepts, pointer wraps 511 -> 0
    cycle(1'b1, LW'(ML), 1'b0, '0);
    for (int i = 0; i < 2 * ML; i++) begin
      cycle(1'b0, '0, 1'b1, DW'(i));
      if (i == ML) chk("max_first_out", out_data, DW'(0));
    end
    chk("max_last_out", out_data, DW'(ML - 1));

    // len=1: each output is the previous accepted sample
    cycle(1'b1, LW'(1), 1'b0, '0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, DW'(50 + i));
    chk("len1_out", out_data, DW'(54));

    // Reconfiguration mid-RUN with a colliding sample
    cycle(1'b1, LW'(4), 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, DW'(100 + i));
    cycle(1'b1, LW'(2), 1'b1, DW'(999));
    chk("reconf_drop_ov", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, DW'(200 + i));
    chk("reconf_first_ov", out_valid, 1'b1);
    chk("reconf_first_od", out_data, DW'(200));

    // Illegal lengths
    cycle(1'b1, LW'(0), 1'b0, '0);
    chk("len0_err", cfg_err, 1'b1);
    cycle(1'b0, '0, 1'b1, DW'(7));
    chk("len0_err_pulse", cfg_err, 1'b0);
    cycle(1'b1, LW'(ML + 1), 1'b1, DW'(8));
    chk("len513_err", cfg_err, 1'b1);
    chk("len513_in_ready", in_ready, 1'b0);
    cycle(1'b0, '0, 1'b1, DW'(9));

    // Async reset mid-RUN with a valid output pending
    cycle(1'b1, LW'(2), 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, DW'(300 + i));
    chk("pre_rst_ov", out_valid, 1'b1);
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_primed", primed, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_ram_we", ram_we, 1'b0);
    chk("arst_ram_re", ram_re, 1'b0);
    chk("arst_waddr", ram_waddr, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Randomized traffic with occasional (sometimes illegal) reloads
    for (int i = 0; i < 3000; i++) begin
      bit            ld;
      logic [LW-1:0] len;
      int            sel;
      ld  = ($urandom_range(0, 39) == 0) || (i == 0);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      len = '0;
      else if (sel == 1) len = LW'(ML + 1 + int'($urandom_range(0, (1 << LW) - ML - 2)));
      else if (sel == 2) len = LW'($urandom_range(1, ML));
      else               len = LW'($urandom_range(1, 8));
      cycle(ld, len, ($urandom_range(0, 3) != 0), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
